// File: rtl/rs_param_station_if.sv
// +----------------------------------------------------------------------------+
// | rs_param_station_if                                                        |
// | Dispatch, result-broadcast and issue bundle for the reservation station.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface rs_param_station_if #(
  parameter int DEPTH   = 16,
  parameter int XLEN    = 32,
  parameter int TAG_W   = 4,
  parameter int OP_W    = 6,
  parameter int NUM_CDB = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                     disp_valid;
  logic                     disp_ready;
  logic [OP_W-1:0]          disp_op;
  logic [XLEN-1:0]          disp_imm;
  logic [XLEN-1:0]          disp_pc;
  logic [TAG_W-1:0]         disp_rd_tag;
  logic                     disp_rs1_rdy;
  logic [XLEN-1:0]          disp_rs1_val;
  logic [TAG_W-1:0]         disp_rs1_tag;
  logic                     disp_rs2_rdy;
  logic [XLEN-1:0]          disp_rs2_val;
  logic [TAG_W-1:0]         disp_rs2_tag;
  logic [NUM_CDB-1:0]       cdb_valid;
  logic [NUM_CDB*TAG_W-1:0] cdb_tag;
  logic [NUM_CDB*XLEN-1:0]  cdb_data;
  logic                     iss_valid;
  logic                     iss_ready;
  logic [OP_W-1:0]          iss_op;
  logic [XLEN-1:0]          iss_imm;
  logic [XLEN-1:0]          iss_pc;
  logic [TAG_W-1:0]         iss_rd_tag;
  logic [XLEN-1:0]          iss_rs1_val;
  logic [XLEN-1:0]          iss_rs2_val;
  logic [CNT_W-1:0]         count;

  modport master (
    output disp_valid, disp_op, disp_imm, disp_pc, disp_rd_tag,
           disp_rs1_rdy, disp_rs1_val, disp_rs1_tag,
           disp_rs2_rdy, disp_rs2_val, disp_rs2_tag,
           cdb_valid, cdb_tag, cdb_data, iss_ready,
    input  disp_ready, iss_valid, iss_op, iss_imm, iss_pc, iss_rd_tag,
           iss_rs1_val, iss_rs2_val, count
  );

  modport slave (
    input  disp_valid, disp_op, disp_imm, disp_pc, disp_rd_tag,
           disp_rs1_rdy, disp_rs1_val, disp_rs1_tag,
           disp_rs2_rdy, disp_rs2_val, disp_rs2_tag,
           cdb_valid, cdb_tag, cdb_data, iss_ready,
    output disp_ready, iss_valid, iss_op, iss_imm, iss_pc, iss_rd_tag,
           iss_rs1_val, iss_rs2_val, count
  );
endinterface

`default_nettype wire

// File: rtl/rs_param_station.sv
// +----------------------------------------------------------------------------+
// | rs_param_station                                                           |
// | Reservation station: CDB wakeup with dispatch bypass, lowest-index issue.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rs_param_station #(
  parameter int DEPTH   = 16,
  parameter int XLEN    = 32,
  parameter int TAG_W   = 4,
  parameter int OP_W    = 6,
  parameter int NUM_CDB = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  rs_param_station_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0] busy_q, busy_d, rs1_rdy_q, rs1_rdy_d, rs2_rdy_q, rs2_rdy_d;
  logic [OP_W-1:0]  op_q      [DEPTH];
  logic [OP_W-1:0]  op_d      [DEPTH];
  logic [XLEN-1:0]  imm_q     [DEPTH];
  logic [XLEN-1:0]  imm_d     [DEPTH];
  logic [XLEN-1:0]  pc_q      [DEPTH];
  logic [XLEN-1:0]  pc_d      [DEPTH];
  logic [TAG_W-1:0] rd_tag_q  [DEPTH];
  logic [TAG_W-1:0] rd_tag_d  [DEPTH];
  logic [XLEN-1:0]  rs1_val_q [DEPTH];
  logic [XLEN-1:0]  rs1_val_d [DEPTH];
  logic [TAG_W-1:0] rs1_tag_q [DEPTH];
  logic [TAG_W-1:0] rs1_tag_d [DEPTH];
  logic [XLEN-1:0]  rs2_val_q [DEPTH];
  logic [XLEN-1:0]  rs2_val_d [DEPTH];
  logic [TAG_W-1:0] rs2_tag_q [DEPTH];
  logic [TAG_W-1:0] rs2_tag_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

  logic [IDX_W-1:0] free_idx, sel_idx;
  logic             cand, disp_fire, iss_fire;
  logic [XLEN:0]    byp1, byp2, wk1, wk2;

  // Returns {hit, data}; scanning downward lets the lowest channel win.
  function automatic logic [XLEN:0] cdb_match(
    input logic [TAG_W-1:0]         tag,
    input logic [NUM_CDB-1:0]       vld,
    input logic [NUM_CDB*TAG_W-1:0] tags,
    input logic [NUM_CDB*XLEN-1:0]  data
  );
    logic [XLEN:0] r;
    r = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (vld[c] && (tags[c*TAG_W +: TAG_W] == tag)) r = {1'b1, data[c*XLEN +: XLEN]};
    end
    return r;
  endfunction

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IDX_W'(i);
    end
  end

  // A presented candidate that stalls is locked so the ALU sees stable fields.
  always_comb begin
    cand    = 1'b0;
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (busy_q[i] && rs1_rdy_q[i] && rs2_rdy_q[i]) begin
        cand    = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
    if (lock_q) begin
      cand    = 1'b1;
      sel_idx = lock_idx_q;
    end
  end

  assign disp_fire = bus.disp_valid & bus.disp_ready;
  assign iss_fire  = bus.iss_valid & bus.iss_ready;
  assign byp1 = cdb_match(bus.disp_rs1_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
  assign byp2 = cdb_match(bus.disp_rs2_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);

  always_comb begin
    busy_d     = busy_q;
    rs1_rdy_d  = rs1_rdy_q;
    rs2_rdy_d  = rs2_rdy_q;
    op_d       = op_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    rd_tag_d   = rd_tag_q;
    rs1_val_d  = rs1_val_q;
    rs1_tag_d  = rs1_tag_q;
    rs2_val_d  = rs2_val_q;
    rs2_tag_d  = rs2_tag_q;
    count_d    = count_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    wk1        = '0;
    wk2        = '0;
    if (clr) begin
      busy_d  = '0;
      count_d = '0;
      lock_d  = 1'b0;
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_q[i] && !(iss_fire && (sel_idx == IDX_W'(i)))) begin
          wk1 = cdb_match(rs1_tag_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
          wk2 = cdb_match(rs2_tag_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
          if (!rs1_rdy_q[i] && wk1[XLEN]) begin
            rs1_rdy_d[i] = 1'b1;
            rs1_val_d[i] = wk1[XLEN-1:0];
          end
          if (!rs2_rdy_q[i] && wk2[XLEN]) begin
            rs2_rdy_d[i] = 1'b1;
            rs2_val_d[i] = wk2[XLEN-1:0];
          end
        end
      end
      if (iss_fire) begin
        busy_d[sel_idx] = 1'b0;
        lock_d          = 1'b0;
      end else if (bus.iss_valid) begin
        lock_d     = 1'b1;
        lock_idx_d = sel_idx;
      end
      if (disp_fire) begin
        busy_d[free_idx]    = 1'b1;
        op_d[free_idx]      = bus.disp_op;
        imm_d[free_idx]     = bus.disp_imm;
        pc_d[free_idx]      = bus.disp_pc;
        rd_tag_d[free_idx]  = bus.disp_rd_tag;
        rs1_tag_d[free_idx] = bus.disp_rs1_tag;
        rs2_tag_d[free_idx] = bus.disp_rs2_tag;
        rs1_rdy_d[free_idx] = bus.disp_rs1_rdy | byp1[XLEN];
        rs2_rdy_d[free_idx] = bus.disp_rs2_rdy | byp2[XLEN];
        rs1_val_d[free_idx] = bus.disp_rs1_rdy ? bus.disp_rs1_val : byp1[XLEN-1:0];
        rs2_val_d[free_idx] = bus.disp_rs2_rdy ? bus.disp_rs2_val : byp2[XLEN-1:0];
      end
      if (disp_fire && !iss_fire)      count_d = count_q + 1'b1;
      else if (!disp_fire && iss_fire) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q  <= '0;
      count_q <= '0;
      lock_q  <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      lock_q  <= lock_d;
    end
  end

  always_ff @(posedge clk) begin
    rs1_rdy_q  <= rs1_rdy_d;
    rs2_rdy_q  <= rs2_rdy_d;
    op_q       <= op_d;
    imm_q      <= imm_d;
    pc_q       <= pc_d;
    rd_tag_q   <= rd_tag_d;
    rs1_val_q  <= rs1_val_d;
    rs1_tag_q  <= rs1_tag_d;
    rs2_val_q  <= rs2_val_d;
    rs2_tag_q  <= rs2_tag_d;
    lock_idx_q <= lock_idx_d;
  end

  assign bus.disp_ready  = rdy & ~clr & (count_q < FULL_CNT);
  assign bus.iss_valid   = rdy & ~clr & cand;
  assign bus.iss_op      = op_q[sel_idx];
  assign bus.iss_imm     = imm_q[sel_idx];
  assign bus.iss_pc      = pc_q[sel_idx];
  assign bus.iss_rd_tag  = rd_tag_q[sel_idx];
  assign bus.iss_rs1_val = rs1_val_q[sel_idx];
  assign bus.iss_rs2_val = rs2_val_q[sel_idx];
  assign bus.count       = count_q;

endmodule

`default_nettype wire
